// File: rtl/jam_pkg.sv
// Shared types and helpers for the exhaustive job-assignment solver.
// Permutation storage is sized for the largest supported N.
package jam_pkg;

   localparam int MAX_N = 8;
   localparam int PIW   = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_CMP,
      ST_NEXT,
      ST_DONE
   } state_t;

   // Slot k holds the job assigned to worker k; slots at or above N never move.
   typedef logic [MAX_N-1:0][PIW-1:0] perm_t;

   function automatic longint unsigned factorial(input int n);
      longint unsigned f;
      f = 64'd1;
      for (int k = 2; k <= n; k++) begin
         f = f * 64'(k);
      end
      return f;
   endfunction

   function automatic perm_t identity_perm();
      perm_t p;
      for (int k = 0; k < MAX_N; k++) begin
         p[k] = PIW'(k);
      end
      return p;
   endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational successor of a permutation in lexicographic order.
// The last flag marks a strictly descending permutation, which has no successor.
module jam_next_perm
   import jam_pkg::*;
#(
   parameter int N = 8
) (
   input  perm_t perm,
   output perm_t next_perm,
   output logic  last
);

   logic [PIW-1:0] piv;
   logic [PIW-1:0] succ;
   logic           has_ascent;
   perm_t          swapped;

   // Rightmost ascent: later matches overwrite earlier ones.
   always_comb begin
      has_ascent = 1'b0;
      piv        = '0;
      for (int k = 0; k < N - 1; k++) begin
         if (perm[k] < perm[k+1]) begin
            has_ascent = 1'b1;
            piv        = PIW'(k);
         end
      end
   end

   // The suffix is descending, so the rightmost larger element is the smallest larger one.
   always_comb begin
      succ = piv;
      for (int k = 0; k < N; k++) begin
         if ((PIW'(k) > piv) && (perm[k] > perm[piv])) begin
            succ = PIW'(k);
         end
      end
   end

   always_comb begin
      swapped       = perm;
      swapped[piv]  = perm[succ];
      swapped[succ] = perm[piv];
   end

   // Mirror index of k within piv+1..N-1; modulo-2^PIW arithmetic stays exact here.
   always_comb begin
      next_perm = swapped;
      for (int k = 0; k < N; k++) begin
         if (PIW'(k) > piv) begin
            next_perm[k] = swapped[piv + PIW'(N) - PIW'(k)];
         end
      end
   end

   assign last = !has_ascent;

endmodule

// File: rtl/jam_param.sv
// Parametrised exhaustive job-assignment solver: walks all N! permutations,
// sums costs from an external ROM and keeps the best total, tie count and first winner.
module jam_param
   import jam_pkg::*;
#(
   parameter int N   = 8,
   parameter int CW  = 7,
   parameter int IW  = $clog2(N),
   parameter int SW  = CW + $clog2(N),
   parameter int MCW = 16
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            start,
   input  logic            mode_max,
   output logic [IW-1:0]   W,
   output logic [IW-1:0]   J,
   input  logic [CW-1:0]   Cost,
   output logic            busy,
   output logic            Valid,
   output logic [SW-1:0]   BestCost,
   output logic [MCW-1:0]  MatchCount,
   output logic [N*IW-1:0] BestPerm
);

   if ((N < 2) || (N > MAX_N)) begin : g_bad_n
      $error("jam_param: N must lie in 2..8");
   end
   if ((64'd1 << MCW) <= factorial(N)) begin : g_bad_mcw
      $error("jam_param: MCW too narrow to count N! permutations");
   end

   localparam logic [SW-1:0]  COST_ONES  = '1;
   localparam logic [MCW-1:0] COUNT_ONES = '1;

   state_t         state;
   perm_t          perm;
   perm_t          best_perm;
   perm_t          next_perm;
   logic           perm_last;
   logic [PIW-1:0] idx;
   logic [SW-1:0]  acc;
   logic           max_mode;
   logic           better;

   jam_next_perm #(
      .N(N)
   ) u_next (
      .perm      (perm),
      .next_perm (next_perm),
      .last      (perm_last)
   );

   assign better = max_mode ? (acc > BestCost) : (acc < BestCost);

   // idx is parked at 0 outside FETCH, which keeps the ROM address at worker 0 when idle.
   assign W = idx[IW-1:0];
   assign J = perm[idx][IW-1:0];

   for (genvar k = 0; k < N; k++) begin : g_best
      assign BestPerm[k*IW +: IW] = best_perm[k][IW-1:0];
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         Valid      <= 1'b0;
         idx        <= '0;
         acc        <= '0;
         max_mode   <= 1'b0;
         perm       <= identity_perm();
         best_perm  <= identity_perm();
         BestCost   <= '0;
         MatchCount <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  max_mode   <= mode_max;
                  perm       <= identity_perm();
                  idx        <= '0;
                  acc        <= '0;
                  BestCost   <= mode_max ? '0 : COST_ONES;
                  MatchCount <= '0;
                  Valid      <= 1'b0;
                  busy       <= 1'b1;
                  state      <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               acc <= acc + SW'(Cost);
               if (idx == PIW'(N - 1)) begin
                  idx   <= '0;
                  state <= ST_CMP;
               end else begin
                  idx <= idx + PIW'(1);
               end
            end
            ST_CMP: begin
               // Ties never replace best_perm, so the earliest winner in lexicographic order stays.
               if (better) begin
                  BestCost   <= acc;
                  MatchCount <= MCW'(1);
                  best_perm  <= perm;
               end else if ((acc == BestCost) && (MatchCount != COUNT_ONES)) begin
                  MatchCount <= MatchCount + MCW'(1);
               end
               if (perm_last) begin
                  Valid <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_DONE;
               end else begin
                  state <= ST_NEXT;
               end
            end
            ST_NEXT: begin
               perm  <= next_perm;
               acc   <= '0;
               idx   <= '0;
               state <= ST_FETCH;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jam_param.sv
// Randomised self-checking bench for jam_param with a brute-force reference model.
// Two instances (N=5 and N=3) keep full runs short.
`timescale 1ns/1ps
module tb_jam_param;

   localparam int NA    = 5;
   localparam int CWA   = 5;
   localparam int IWA   = $clog2(NA);
   localparam int SWA   = CWA + $clog2(NA);
   localparam int NB    = 3;
   localparam int CWB   = 4;
   localparam int IWB   = $clog2(NB);
   localparam int SWB   = CWB + $clog2(NB);
   localparam int MCW   = 16;
   localparam int LIMIT = 5000;

   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic start_a = 1'b0;
   logic mode_a  = 1'b0;
   logic start_b = 1'b0;
   logic mode_b  = 1'b0;

   logic [IWA-1:0]    w_a, j_a;
   logic [CWA-1:0]    cost_a;
   logic              busy_a, valid_a;
   logic [SWA-1:0]    best_a;
   logic [MCW-1:0]    match_a;
   logic [NA*IWA-1:0] perm_a;

   logic [IWB-1:0]    w_b, j_b;
   logic [CWB-1:0]    cost_b;
   logic              busy_b, valid_b;
   logic [SWB-1:0]    best_b;
   logic [MCW-1:0]    match_b;
   logic [NB*IWB-1:0] perm_b;

   int cm_a [8][8];
   int cm_b [4][4];
   int check_count = 0;
   int error_count = 0;

   always #5 clk = ~clk;

   assign cost_a = CWA'(cm_a[w_a][j_a]);
   assign cost_b = CWB'(cm_b[w_b][j_b]);

   jam_param #(.N(NA), .CW(CWA), .MCW(MCW)) u_dut_a (
      .CLK(clk), .RST_N(rst_n), .start(start_a), .mode_max(mode_a),
      .W(w_a), .J(j_a), .Cost(cost_a), .busy(busy_a), .Valid(valid_a),
      .BestCost(best_a), .MatchCount(match_a), .BestPerm(perm_a)
   );

   jam_param #(.N(NB), .CW(CWB), .MCW(MCW)) u_dut_b (
      .CLK(clk), .RST_N(rst_n), .start(start_b), .mode_max(mode_b),
      .W(w_b), .J(j_b), .Cost(cost_b), .busy(busy_b), .Valid(valid_b),
      .BestCost(best_b), .MatchCount(match_b), .BestPerm(perm_b)
   );

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic longint fact(input int n);
      longint f = 1;
      for (int k = 2; k <= n; k++) f = f * k;
      return f;
   endfunction

   function automatic longint packIdentity(input int n, input int iw);
      longint v = 0;
      for (int k = 0; k < n; k++) v = v | (longint'(k) << (k * iw));
      return v;
   endfunction

   function automatic int costOf(input bit which, input int w, input int j);
      return which ? cm_b[w][j] : cm_a[w][j];
   endfunction

   // Enumerates every n-digit base-n word in increasing order, keeping only permutations.
   task automatic modelRun(input bit which, input bit mx,
                           output longint best, output longint cnt, output longint bperm);
      int n, iw, sw, total;
      int d [8];
      n     = which ? NB : NA;
      iw    = which ? IWB : IWA;
      sw    = which ? SWB : SWA;
      total = n ** n;
      best  = mx ? 0 : ((longint'(1) << sw) - 1);
      cnt   = 0;
      bperm = packIdentity(n, iw);
      for (int c = 0; c < total; c++) begin
         int     r;
         bit     ok;
         int     s;
         longint pk;
         bit [7:0] seen;
         r = c; ok = 1'b1; s = 0; pk = 0; seen = '0;
         for (int k = n - 1; k >= 0; k--) begin
            d[k] = r % n;
            r    = r / n;
         end
         for (int k = 0; k < n; k++) begin
            if (seen[d[k]]) ok = 1'b0;
            seen[d[k]] = 1'b1;
         end
         if (ok) begin
            for (int k = 0; k < n; k++) begin
               s  = s + costOf(which, k, d[k]);
               pk = pk | (longint'(d[k]) << (k * iw));
            end
            if (mx ? (s > best) : (s < best)) begin
               best = s; cnt = 1; bperm = pk;
            end else if (s == best) begin
               cnt++;
            end
         end
      end
   endtask

   task automatic fillTable(input bit which, input int kind);
      int v;
      for (int w = 0; w < 8; w++) begin
         for (int j = 0; j < 8; j++) begin
            case (kind)
               0:       v = int'($urandom_range(0, 3));
               1:       v = int'($urandom_range(0, which ? 15 : 31));
               2:       v = (w == j) ? 0 : 1;
               3:       v = 5;
               4:       v = w * j;
               5:       v = (w > j) ? (w - j) : (j - w);
               default: v = 0;
            endcase
            if (which) begin
               if (w < 4 && j < 4) cm_b[w][j] = v;
            end else begin
               cm_a[w][j] = v;
            end
         end
      end
   endtask

   // Counts edges from the accepting edge until Valid; optionally pulses start mid-run.
   task automatic runDut(input bit which, input bit mx, input int pulse_at, output int cycles);
      @(negedge clk);
      if (which) begin start_b = 1'b1; mode_b = mx; end
      else begin start_a = 1'b1; mode_a = mx; end
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      mode_a  = !mx;  mode_b  = !mx;
      checkOutput("busy_after_start", which ? busy_b : busy_a, 1);
      checkOutput("valid_after_start", which ? valid_b : valid_a, 0);
      cycles = 0;
      while (!(which ? valid_b : valid_a) && cycles < LIMIT) begin
         if (which) start_b = (cycles == pulse_at);
         else start_a = (cycles == pulse_at);
         @(posedge clk); #1;
         cycles++;
      end
      start_a = 1'b0; start_b = 1'b0;
   endtask

   task automatic applyStimulus(input string tag, input bit which, input bit mx, input int pulse_at);
      int cycles, n;
      longint eb, ec, ep;
      n = which ? NB : NA;
      runDut(which, mx, pulse_at, cycles);
      modelRun(which, mx, eb, ec, ep);
      checkOutput({tag, "_cycles"}, cycles, fact(n) * (n + 2) - 1);
      checkOutput({tag, "_best"}, which ? best_b : best_a, eb);
      checkOutput({tag, "_count"}, which ? match_b : match_a, ec);
      checkOutput({tag, "_perm"}, which ? perm_b : perm_a, ep);
      checkOutput({tag, "_busy_done"}, which ? busy_b : busy_a, 0);
      checkOutput({tag, "_w_done"}, which ? w_b : w_a, 0);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_a_busy"}, busy_a, 0);
      checkOutput({tag, "_a_valid"}, valid_a, 0);
      checkOutput({tag, "_a_w"}, w_a, 0);
      checkOutput({tag, "_a_best"}, best_a, 0);
      checkOutput({tag, "_a_count"}, match_a, 0);
      checkOutput({tag, "_a_perm"}, perm_a, packIdentity(NA, IWA));
      checkOutput({tag, "_b_busy"}, busy_b, 0);
      checkOutput({tag, "_b_valid"}, valid_b, 0);
      checkOutput({tag, "_b_w"}, w_b, 0);
      checkOutput({tag, "_b_best"}, best_b, 0);
      checkOutput({tag, "_b_count"}, match_b, 0);
      checkOutput({tag, "_b_perm"}, perm_b, packIdentity(NB, IWB));
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      #12;
      checkResetState("reset");
      rst_n = 1'b1;

      fillTable(0, 2); applyStimulus("a_diag_min", 0, 0, -1);
      fillTable(0, 3); applyStimulus("a_const_min", 0, 0, -1);
      checkOutput("a_const_literal_best", best_a, 25);
      checkOutput("a_const_literal_count", match_a, 120);
      fillTable(0, 4); applyStimulus("a_wj_max", 0, 1, -1);
      checkOutput("a_wj_literal_best", best_a, 30);
      fillTable(0, 6); applyStimulus("a_zero_min", 0, 0, -1);
      applyStimulus("a_zero_max", 0, 1, -1);
      checkOutput("a_zero_max_literal_count", match_a, 120);
      for (int i = 0; i < 4; i++) begin
         fillTable(0, (i % 2 == 0) ? 0 : 1);
         applyStimulus("a_rand", 0, (i % 2 == 1), -1);
      end

      fillTable(1, 5); applyStimulus("b_absdiff_max", 1, 1, -1);
      checkOutput("b_absdiff_literal_best", best_b, 4);
      checkOutput("b_absdiff_literal_count", match_b, 3);
      checkOutput("b_absdiff_literal_perm", perm_b, 9);
      applyStimulus("b_absdiff_min", 1, 0, -1);
      checkOutput("b_absdiff_min_literal_best", best_b, 0);
      fillTable(1, 0); applyStimulus("b_pulse_busy", 1, 0, 10);

      @(negedge clk);
      start_b = 1'b1; mode_b = 1'b0;
      @(posedge clk); #1;
      start_b = 1'b0;
      @(posedge clk); #1;
      checkOutput("b_midrun_busy", busy_b, 1);
      checkOutput("b_midrun_w", w_b, 1);
      checkOutput("b_midrun_j", j_b, 1);
      rst_n = 1'b0;
      #1;
      checkResetState("midrun_reset");
      #2 rst_n = 1'b1;
      applyStimulus("b_after_reset", 1, 0, -1);

      for (int i = 0; i < 4; i++) begin
         fillTable(1, (i < 2) ? 0 : 1);
         applyStimulus("b_rand", 1, (i % 2 == 0), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
